// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversamples sclk/cs/mosi0 in the pclk domain, deserialises
// mosi0 into characters and serialises a host-supplied response onto miso0.
//
// state        | meaning
// -------------+----------------------------------------------------------
// WAIT_CS_HIGH | after reset; ignore bus until cs is seen high (no partial frames)
// IDLE         | cs high, waiting for a cs fall to start a frame
// ACTIVE       | cs low, shifting characters in both directions
`timescale 1ns/1ps
module spi_slave_responder #(
  parameter int unsigned             CHAR_LENGTH = 8,
  parameter logic [CHAR_LENGTH-1:0]  IDLE_FILL   = '1
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_dir,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi0,
  output logic                   miso0,
  output logic                   miso_oe,
  input  logic [CHAR_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [CHAR_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   tx_underrun,
  output logic                   frame_abort
);

  localparam int CNT_W = $clog2(CHAR_LENGTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAR_LENGTH);

  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, ACTIVE} state_e;

  state_e state, state_nxt;

  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;

  logic cpol, cpha, dir;
  logic fresh;
  logic [CHAR_LENGTH-1:0] tx_sh, rx_sh, hold_data;
  logic hold_full;
  logic [CNT_W-1:0] bit_cnt, cnt_inc;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, drive_edge;
  logic start, smp, drv, rld, shift, abort;

  // Two-flop synchronisers plus one delay stage for edge detection. cs resets
  // low so a cs held low through reset is never mistaken for an idle bus.
  always_ff @(posedge pclk) begin
    if (areset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= mosi0;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_d;
  assign sclk_fall   = ~sclk_s2 & sclk_d;
  assign cs_fall     = ~cs_s2 & cs_d;
  assign cs_rise     = cs_s2 & ~cs_d;
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge : trail_edge;

  assign start   = (state == IDLE) && cs_fall;
  assign smp     = (state == ACTIVE) && sample_edge;
  assign drv     = (state == ACTIVE) && drive_edge && !cs_rise;
  assign cnt_inc = bit_cnt + CNT_W'(smp);
  // A drive edge with an empty bit count starts a new character, except the
  // very first drive edge of a CPHA=1 frame whose character loaded at cs fall.
  assign rld     = start || (drv && (bit_cnt == '0) && !fresh);
  assign shift   = drv && (bit_cnt != '0) && (bit_cnt != CNT_FULL);
  // A sample landing together with the cs rise still completes the character.
  assign abort   = (state == ACTIVE) && cs_rise && (cnt_inc != '0) && (cnt_inc != CNT_FULL);

  // State register.
  always_ff @(posedge pclk) begin
    if (areset) state <= WAIT_CS_HIGH;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_CS_HIGH: if (cs_s2)   state_nxt = IDLE;
      IDLE:         if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:       if (cs_rise) state_nxt = IDLE;
      default:                   state_nxt = WAIT_CS_HIGH;
    endcase
  end

  // Pad outputs follow the state; miso0 is the head of the tx shifter.
  always_comb begin
    miso0    = 1'b0;
    miso_oe  = 1'b0;
    tx_ready = ~hold_full;
    if (state == ACTIVE) begin
      miso_oe = 1'b1;
      miso0   = dir ? tx_sh[CHAR_LENGTH-1] : tx_sh[0];
    end
  end

  // Frame configuration, holding register and tx shifter.
  always_ff @(posedge pclk) begin
    if (areset) begin
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      dir         <= 1'b0;
      fresh       <= 1'b0;
      tx_sh       <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (start) begin
        cpol  <= cfg_mode[1];
        cpha  <= cfg_mode[0];
        dir   <= cfg_dir;
        fresh <= 1'b1;
      end else if (smp || drv) begin
        fresh <= 1'b0;
      end
      if (rld) begin
        if (hold_full) begin
          tx_sh <= hold_data;
        end else begin
          tx_sh       <= IDLE_FILL;
          tx_underrun <= 1'b1;
        end
      end else if (shift) begin
        tx_sh <= dir ? {tx_sh[CHAR_LENGTH-2:0], 1'b0} : {1'b0, tx_sh[CHAR_LENGTH-1:1]};
      end
      // A write in the same cycle as a load lands after the load has looked.
      if (tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end else if (rld && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Receive shifter, bit counter and character/abort pulses.
  always_ff @(posedge pclk) begin
    if (areset) begin
      rx_sh       <= '0;
      rx_data     <= '0;
      bit_cnt     <= '0;
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= abort;
      if (smp) begin
        rx_sh <= dir ? {rx_sh[CHAR_LENGTH-2:0], mosi_s2} : {mosi_s2, rx_sh[CHAR_LENGTH-1:1]};
      end
      if (bit_cnt == CNT_FULL) begin
        bit_cnt  <= '0;
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (abort || start) begin
        bit_cnt <= '0;
      end else if (smp) begin
        bit_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a behavioural SPI master plus a response-queue
// model that predicts every character the slave returns and every underrun.
`timescale 1ns/1ps
module tb_spi_slave_responder;

  localparam int W = 8;
  localparam int H = 6;

  logic         pclk;
  logic         areset;
  logic [1:0]   cfg_mode;
  logic         cfg_dir;
  logic         sclk, cs, mosi0;
  logic         miso0, miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, tx_underrun, frame_abort;

  spi_slave_responder #(.CHAR_LENGTH(W), .IDLE_FILL(8'hFF)) dut (
    .pclk        (pclk),
    .areset      (areset),
    .cfg_mode    (cfg_mode),
    .cfg_dir     (cfg_dir),
    .sclk        (sclk),
    .cs          (cs),
    .mosi0       (mosi0),
    .miso0       (miso0),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor
  int rxv_cnt = 0;
  int und_cnt = 0;
  int abt_cnt = 0;
  logic [W-1:0] rx_log[$];

  initial forever begin
    @(negedge pclk);
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun === 1'b1) und_cnt++;
    if (frame_abort === 1'b1) abt_cnt++;
  end

  // Response feeder: offers the next queued character whenever the holding
  // register is empty; an injection request takes priority.
  logic [W-1:0] feed_mem[$];
  int           feed_rd  = 0;
  int           inj_req  = 0;
  int           inj_seen = 0;
  logic [W-1:0] inj_val  = '0;

  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge pclk);
      tx_valid = 1'b0;
      if (areset === 1'b0 && tx_ready === 1'b1) begin
        if (inj_req != inj_seen) begin
          tx_valid = 1'b1;
          tx_data  = inj_val;
          inj_seen++;
        end else if (feed_rd < feed_mem.size()) begin
          tx_valid = 1'b1;
          tx_data  = feed_mem[feed_rd];
          feed_rd++;
        end
      end
    end
  end

  // Reference model: characters handed to the slave and not yet loaded.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rx = '0;
  logic [W-1:0] m_tx[4];

  task automatic push_tx(input logic [W-1:0] v);
    feed_mem.push_back(v);
    exp_q.push_back(v);
  endtask

  // Master transaction. nch characters, the last one cut to last_bits bits.
  task automatic spi_xfer(input logic [1:0] mode, input bit msb, input int nch, input int last_bits,
                          input bit raise_cs, input bit inj, input logic [W-1:0] ival);
    bit cpol, cpha, full;
    int loads, und_exp, n_full, nb, idx;
    int rxv0, und0, abt0, rxl0;
    logic [W-1:0] v;
    logic [W-1:0] exp_ch[4];
    logic [W-1:0] got_ch[4];
    cpol = mode[1];
    cpha = mode[0];
    full = (last_bits == W);
    n_full = full ? nch : nch - 1;
    // One load per character started; CPHA=0 also reloads after the final sample.
    loads = nch + ((full && raise_cs && !cpha) ? 1 : 0);
    und_exp = 0;
    for (int i = 0; i < loads; i++) begin
      if (exp_q.size() > 0) v = exp_q.pop_front();
      else begin
        v = 8'hFF;
        und_exp++;
      end
      if (i == 0 && inj) exp_q.push_back(ival);
      if (i < 4) exp_ch[i] = v;
    end
    rxv0 = rxv_cnt;
    und0 = und_cnt;
    abt0 = abt_cnt;
    rxl0 = rx_log.size();

    cfg_mode = mode;
    cfg_dir  = msb;
    sclk     = cpol;
    repeat (6) @(negedge pclk);
    cs = 1'b0;
    if (inj) begin
      @(posedge pclk);
      @(posedge pclk);
      inj_val = ival;
      inj_req++;
    end
    repeat (8) @(negedge pclk);
    for (int c = 0; c < nch; c++) begin
      nb = (c == nch - 1) ? last_bits : W;
      got_ch[c] = '0;
      for (int b = 0; b < nb; b++) begin
        idx = msb ? (W - 1 - b) : b;
        if (!cpha) begin
          mosi0 = m_tx[c][idx];
          repeat (H) @(negedge pclk);
          got_ch[c] = msb ? {got_ch[c][W-2:0], miso0} : {miso0, got_ch[c][W-1:1]};
          sclk = ~sclk;
          repeat (H) @(negedge pclk);
          sclk = ~sclk;
        end else begin
          sclk  = ~sclk;
          mosi0 = m_tx[c][idx];
          repeat (H) @(negedge pclk);
          got_ch[c] = msb ? {got_ch[c][W-2:0], miso0} : {miso0, got_ch[c][W-1:1]};
          sclk = ~sclk;
          repeat (H) @(negedge pclk);
        end
      end
    end
    repeat (H) @(negedge pclk);
    if (raise_cs) begin
      cs = 1'b1;
      repeat (12) @(negedge pclk);
      for (int c = 0; c < n_full; c++) begin
        check($sformatf("miso_char%0d_m%0d_d%0d", c, mode, msb), got_ch[c], exp_ch[c]);
        check($sformatf("rx_data%0d", c),
              (rx_log.size() > rxl0 + c) ? {24'h0, rx_log[rxl0 + c]} : 32'hDEAD, m_tx[c]);
      end
      check("rx_valid_count", rxv_cnt - rxv0, n_full);
      check("underrun_count", und_cnt - und0, und_exp);
      check("abort_count", abt_cnt - abt0, full ? 0 : 1);
      check("miso_oe_idle", miso_oe, 0);
      check("miso0_idle", miso0, 0);
      if (n_full > 0) last_rx = m_tx[n_full-1];
      check("rx_data_held", rx_data, last_rx);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] r_mode;
    bit         r_dir;
    int         r_nch, r_bits, r_push, rxv_snap;

    areset   = 1'b1;
    cs       = 1'b1;
    sclk     = 1'b0;
    mosi0    = 1'b0;
    cfg_mode = 2'd0;
    cfg_dir  = 1'b1;
    repeat (4) @(negedge pclk);
    check("rst_miso0", miso0, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_abort", frame_abort, 0);
    areset = 1'b0;
    repeat (6) @(negedge pclk);

    // Mode 0 MSB-first, preloaded response
    push_tx(8'hA5);
    m_tx[0] = 8'h3C;
    spi_xfer(2'd0, 1'b1, 1, W, 1'b1, 1'b0, 8'h00);

    // Every mode in both bit orders
    for (int m = 0; m < 4; m++) begin
      for (int d = 0; d < 2; d++) begin
        push_tx(8'h7E);
        m_tx[0] = 8'h81;
        spi_xfer(2'(m), 1'(d), 1, W, 1'b1, 1'b0, 8'h00);
      end
    end

    // Mode 3 continuous frame, two responses for three characters
    push_tx(8'h11);
    push_tx(8'h22);
    m_tx[0] = 8'hC1;
    m_tx[1] = 8'h5D;
    m_tx[2] = 8'h96;
    spi_xfer(2'd3, 1'b1, 3, W, 1'b1, 1'b0, 8'h00);

    // cs rises after five bits
    m_tx[0] = 8'hF0;
    spi_xfer(2'd0, 1'b1, 1, 5, 1'b1, 1'b0, 8'h00);

    // Response written in the same cycle as the cs-fall load
    m_tx[0] = 8'h29;
    m_tx[1] = 8'hB4;
    spi_xfer(2'd1, 1'b0, 2, W, 1'b1, 1'b1, 8'h3C);

    // Reset in the middle of a character with cs held low
    m_tx[0] = 8'hC3;
    spi_xfer(2'd0, 1'b1, 1, 3, 1'b0, 1'b0, 8'h00);
    rxv_snap = rxv_cnt;
    areset = 1'b1;
    repeat (2) @(negedge pclk);
    check("mid_rst_miso0", miso0, 0);
    check("mid_rst_miso_oe", miso_oe, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_data", rx_data, 0);
    areset = 1'b0;
    exp_q.delete();
    last_rx = '0;
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      repeat (H) @(negedge pclk);
      check("post_rst_miso_oe", miso_oe, 0);
    end
    check("post_rst_rx_valid", rxv_cnt - rxv_snap, 0);
    cs = 1'b1;
    repeat (8) @(negedge pclk);
    push_tx(8'h5A);
    m_tx[0] = 8'($urandom);
    spi_xfer(2'd0, 1'b1, 1, W, 1'b1, 1'b0, 8'h00);

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      r_mode = 2'($urandom_range(0, 3));
      r_dir  = 1'($urandom_range(0, 1));
      r_nch  = $urandom_range(1, 3);
      r_bits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W - 1) : W;
      r_push = $urandom_range(0, r_nch + 1);
      for (int i = 0; i < r_push; i++) push_tx(8'($urandom));
      for (int i = 0; i < r_nch; i++) m_tx[i] = 8'($urandom);
      spi_xfer(r_mode, r_dir, r_nch, r_bits, 1'b1, 1'b0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
